// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional macro PS2_TX_TIMEOUT_EN adds start/bit timeouts and the error_timeout pulse.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       inclock,
    input  logic       resetn,
    input  logic       send_command,
    input  logic [7:0] command,
    inout  wire        ps2_clock,
    inout  wire        ps2_data,
    output logic       busy,
    output logic       command_sent,
    output logic       error_nack,
    output logic       error_timeout
);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    state_t          state_q, state_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]   inh_cnt_q, inh_cnt_d;
    logic            data_low_q, data_low_d;
    logic            idle_seen_q, idle_seen_d;
    logic            sent_q, sent_d;
    logic            nack_q, nack_d;
    logic [1:0]      clk_sync_q, clk_sync_d;
    logic [1:0]      data_sync_q, data_sync_d;
    logic            clk_prev_q, clk_prev_d;
    logic            fall;
    logic            to_expire;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clock};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
    end

    assign fall = clk_prev_q & ~clk_sync_q[1];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int TO_W   = $clog2(TO_MAX + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_limit;
    logic            timeout_q;

    // Before the first device edge the longer start window applies.
    assign to_limit = (state_q == BITS && bit_cnt_q == 4'd0) ? TO_W'(START_TIMEOUT - 1)
                                                             : TO_W'(BIT_TIMEOUT - 1);

    always_comb begin
        to_expire = 1'b0;
        to_cnt_d  = to_cnt_q;
        if (state_q == REQ || fall) begin
            to_cnt_d = '0;
        end else if (state_q == BITS || state_q == ACK) begin
            if (to_cnt_q == to_limit) to_expire = 1'b1;
            else                      to_cnt_d  = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= to_expire;
        end
    end

    assign error_timeout = timeout_q;
`else
    assign to_expire = 1'b0;
    // Always 0 for any legal parameter set; the timeout parameters stay for override compatibility.
    assign error_timeout = (START_TIMEOUT < 0) || (BIT_TIMEOUT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        data_low_d  = data_low_q;
        idle_seen_d = 1'b0;
        sent_d      = 1'b0;
        nack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                inh_cnt_d = '0;
                if (send_command) begin
                    shift_d  = command;
                    parity_d = ~^command;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) state_d = REQ;
                else                                       inh_cnt_d = inh_cnt_q + 1'b1;
            end
            REQ: begin
                bit_cnt_d  = '0;
                data_low_d = 1'b1;
                state_d    = BITS;
            end
            BITS: begin
                if (to_expire) begin
                    data_low_d = 1'b0;
                    state_d    = WAIT_IDLE;
                end else if (fall) begin
                    if (bit_cnt_q < 4'd8) begin
                        data_low_d = ~shift_q[bit_cnt_q[2:0]];
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end else if (bit_cnt_q == 4'd8) begin
                        data_low_d = ~parity_q;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = ACK;
                    end
                end
            end
            ACK: begin
                if (to_expire) begin
                    state_d = WAIT_IDLE;
                end else if (fall) begin
                    if (data_sync_q[1]) nack_d = 1'b1;
                    else                sent_d = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync_q[1] && data_sync_q[1]) begin
                    idle_seen_d = 1'b1;
                    if (idle_seen_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            data_low_q  <= 1'b0;
            idle_seen_q <= 1'b0;
            sent_q      <= 1'b0;
            nack_q      <= 1'b0;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            data_low_q  <= data_low_d;
            idle_seen_q <= idle_seen_d;
            sent_q      <= sent_d;
            nack_q      <= nack_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    // Start bit is driven combinationally in REQ, then held by data_low_q.
    assign ps2_clock    = (state_q == INHIBIT) ? 1'b0 : 1'bz;
    assign ps2_data     = ((state_q == REQ) || data_low_q) ? 1'b0 : 1'bz;
    assign busy         = (state_q != IDLE);
    assign command_sent = sent_q;
    assign error_nack   = nack_q;
endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with a PS/2 device model on pulled-up open-drain lines.
module tb_ps2_command_tx;
    localparam int START_TO = 3000;
    localparam int BIT_TO   = 1000;
    localparam int HALF     = 20;

    logic       inclock = 1'b0;
    logic       resetn = 1'b0;
    logic       send_command = 1'b0;
    logic [7:0] command = 8'h00;
    logic       busy, command_sent, error_nack, error_timeout;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;

    int tests = 0;
    int fails = 0;
    int n_sent = 0;
    int n_nack = 0;
    int n_to = 0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_command_tx #(
        .INHIBIT_CYCLES(5000),
        .START_TIMEOUT (START_TO),
        .BIT_TIMEOUT   (BIT_TO)
    ) dut (
        .inclock      (inclock),
        .resetn       (resetn),
        .send_command (send_command),
        .command      (command),
        .ps2_clock    (ps2_clk),
        .ps2_data     (ps2_dat),
        .busy         (busy),
        .command_sent (command_sent),
        .error_nack   (error_nack),
        .error_timeout(error_timeout)
    );

    always #5 inclock = ~inclock;

    always @(negedge inclock) begin
        if (command_sent === 1'b1)  n_sent++;
        if (error_nack === 1'b1)    n_nack++;
        if (error_timeout === 1'b1) n_to++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Device side: wait for request-to-send, then clock out 'pulses' cycles sampling data.
    task automatic device_xfer(input int pulses, input bit ack, output logic [10:0] frame,
                               output int inh, output bit rts_ok, output logic busy_hold);
        inh = 0; rts_ok = 1'b0; frame = '1; busy_hold = 1'bx;
        for (int i = 0; i < 8000; i++) begin
            if (ps2_clk === 1'b0) inh++;
            else if (ps2_dat === 1'b0) begin rts_ok = 1'b1; break; end
            @(negedge inclock);
        end
        if (!rts_ok) return;
        frame[0] = ps2_dat;
        repeat (10) @(negedge inclock);
        for (int p = 1; p <= pulses; p++) begin
            if (p == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (2) @(negedge inclock);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge inclock);
            if (p <= 10) frame[p] = ps2_dat;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge inclock);
        end
        if (pulses == 11 && ack) begin
            busy_hold = busy;
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] b, input bit ack, input bit inject,
                           output logic [10:0] frame, output int inh, output bit rts_ok,
                           output logic busy_acc, output logic busy_hold, output bit idle_ok);
        @(negedge inclock);
        command = b; send_command = 1'b1;
        @(negedge inclock);
        send_command = 1'b0;
        busy_acc = busy;
        if (inject) begin
            repeat (3) @(negedge inclock);
            command = 8'h12; send_command = 1'b1;
            @(negedge inclock);
            send_command = 1'b0;
        end
        device_xfer(11, ack, frame, inh, rts_ok, busy_hold);
        idle_ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge inclock);
            if (busy === 1'b0) begin idle_ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge inclock);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (ps2_clk !== 1'b1) begin fails++; $display("FAIL reset_clk: got %b expected 1", ps2_clk); end
        tests++; if (ps2_dat !== 1'b1) begin fails++; $display("FAIL reset_dat: got %b expected 1", ps2_dat); end
        tests++; if ({command_sent, error_nack, error_timeout} !== 3'b000) begin
            fails++; $display("FAIL reset_status: got %b expected 000", {command_sent, error_nack, error_timeout});
        end
        resetn = 1'b1;
        repeat (3) @(negedge inclock);
    endtask

    task automatic test_send_ed();
        logic [10:0] fr; int inh; bit rts; logic ba, bh; bit idl; int s0, k0;
        s0 = n_sent; k0 = n_nack;
        run_txn(8'hED, 1'b1, 1'b0, fr, inh, rts, ba, bh, idl);
        tests++; if (ba !== 1'b1) begin fails++; $display("FAIL ed_busy_accept: got %b expected 1", ba); end
        tests++; if (!rts) begin fails++; $display("FAIL ed_rts: got 0 expected 1"); end
        tests++; if (inh != 5000) begin fails++; $display("FAIL ed_inhibit: got %0d expected 5000", inh); end
        tests++; if (fr !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
            fails++; $display("FAIL ed_frame: got %b expected %b", fr, {1'b1, 1'b1, 8'hED, 1'b0});
        end
        tests++; if (bh !== 1'b1) begin fails++; $display("FAIL ed_busy_hold: got %b expected 1", bh); end
        tests++; if (!idl) begin fails++; $display("FAIL ed_busy_fall: got 1 expected 0"); end
        tests++; if (n_sent - s0 != 1) begin fails++; $display("FAIL ed_sent: got %0d expected 1", n_sent - s0); end
        tests++; if (n_nack - k0 != 0) begin fails++; $display("FAIL ed_nack: got %0d expected 0", n_nack - k0); end
    endtask

    task automatic test_send_f4();
        logic [10:0] fr; int inh; bit rts; logic ba, bh; bit idl; int s0;
        s0 = n_sent;
        run_txn(8'hF4, 1'b1, 1'b0, fr, inh, rts, ba, bh, idl);
        tests++; if (inh != 5000) begin fails++; $display("FAIL f4_inhibit: got %0d expected 5000", inh); end
        tests++; if (fr !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
            fails++; $display("FAIL f4_frame: got %b expected %b", fr, {1'b1, 1'b0, 8'hF4, 1'b0});
        end
        tests++; if (n_sent - s0 != 1) begin fails++; $display("FAIL f4_sent: got %0d expected 1", n_sent - s0); end
        tests++; if (!idl) begin fails++; $display("FAIL f4_idle: got busy expected idle"); end
    endtask

    task automatic test_nack_00();
        logic [10:0] fr; int inh; bit rts; logic ba, bh; bit idl; int s0, k0;
        s0 = n_sent; k0 = n_nack;
        run_txn(8'h00, 1'b0, 1'b0, fr, inh, rts, ba, bh, idl);
        tests++; if (fr !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            fails++; $display("FAIL nack_frame: got %b expected %b", fr, {1'b1, 1'b1, 8'h00, 1'b0});
        end
        tests++; if (n_nack - k0 != 1) begin fails++; $display("FAIL nack_pulse: got %0d expected 1", n_nack - k0); end
        tests++; if (n_sent - s0 != 0) begin fails++; $display("FAIL nack_sent: got %0d expected 0", n_sent - s0); end
        tests++; if (!idl) begin fails++; $display("FAIL nack_idle: got busy expected idle"); end
    endtask

`ifdef PS2_TX_TIMEOUT_EN
    task automatic test_timeout();
        bit rts; bit seen; int n; int t0, s0, k0;
        t0 = n_to; s0 = n_sent; k0 = n_nack; rts = 1'b0; seen = 1'b0; n = 0;
        @(negedge inclock);
        command = 8'hFF; send_command = 1'b1;
        @(negedge inclock);
        send_command = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (ps2_clk === 1'b1 && ps2_dat === 1'b0) begin rts = 1'b1; break; end
            @(negedge inclock);
        end
        tests++; if (!rts) begin fails++; $display("FAIL to_rts: got 0 expected 1"); end
        for (int i = 0; i < START_TO + 50; i++) begin
            @(negedge inclock);
            n++;
            if (error_timeout === 1'b1) begin seen = 1'b1; break; end
        end
        tests++; if (!seen || n < START_TO || n > START_TO + 2) begin
            fails++; $display("FAIL to_latency: got %0d expected %0d..%0d", n, START_TO, START_TO + 2);
        end
        repeat (10) @(negedge inclock);
        tests++; if ({ps2_clk, ps2_dat} !== 2'b11) begin fails++; $display("FAIL to_lines: got %b expected 11", {ps2_clk, ps2_dat}); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b expected 0", busy); end
        tests++; if (n_to - t0 != 1 || n_sent != s0 || n_nack != k0) begin
            fails++; $display("FAIL to_pulses: got to=%0d sent=%0d nack=%0d expected 1 0 0", n_to - t0, n_sent - s0, n_nack - k0);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [10:0] fr; int inh; bit rts; logic bh; int s0, k0, t0;
        logic [10:0] fr2; int inh2; bit rts2; logic ba2, bh2; bit idl2;
        @(negedge inclock);
        command = 8'hAA; send_command = 1'b1;
        @(negedge inclock);
        send_command = 1'b0;
        device_xfer(4, 1'b0, fr, inh, rts, bh);
        s0 = n_sent; k0 = n_nack; t0 = n_to;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
        resetn = 1'b0;
        @(negedge inclock);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        tests++; if ({ps2_clk, ps2_dat} !== 2'b11) begin fails++; $display("FAIL rst_mid_lines: got %b expected 11", {ps2_clk, ps2_dat}); end
        resetn = 1'b1;
        repeat (20) @(negedge inclock);
        tests++; if (n_sent != s0 || n_nack != k0 || n_to != t0) begin
            fails++; $display("FAIL rst_mid_pulse: got sent=%0d nack=%0d to=%0d expected 0 0 0", n_sent - s0, n_nack - k0, n_to - t0);
        end
        run_txn(8'h55, 1'b1, 1'b0, fr2, inh2, rts2, ba2, bh2, idl2);
        tests++; if (fr2 !== {1'b1, 1'b1, 8'h55, 1'b0}) begin
            fails++; $display("FAIL rst_after_frame: got %b expected %b", fr2, {1'b1, 1'b1, 8'h55, 1'b0});
        end
        tests++; if (n_sent - s0 != 1) begin fails++; $display("FAIL rst_after_sent: got %0d expected 1", n_sent - s0); end
    endtask

    task automatic test_ignore_busy();
        logic [10:0] fr; int inh; bit rts; logic ba, bh; bit idl; int s0; bit quiet;
        s0 = n_sent; quiet = 1'b1;
        run_txn(8'h3C, 1'b1, 1'b1, fr, inh, rts, ba, bh, idl);
        tests++; if (fr !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin
            fails++; $display("FAIL ign_frame: got %b expected %b", fr, {1'b1, 1'b1, 8'h3C, 1'b0});
        end
        tests++; if (n_sent - s0 != 1) begin fails++; $display("FAIL ign_sent: got %0d expected 1", n_sent - s0); end
        for (int i = 0; i < 100; i++) begin
            @(negedge inclock);
            if (busy !== 1'b0 || ps2_clk !== 1'b1) quiet = 1'b0;
        end
        tests++; if (!quiet) begin fails++; $display("FAIL ign_no_queue: got activity expected idle"); end
    endtask

    task automatic test_no_spurious_timeout();
        tests++; if (n_to != 0) begin fails++; $display("FAIL spurious_timeout: got %0d expected 0", n_to); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_send_f4();
        test_nack_00();
        test_reset_mid();
        test_ignore_busy();
`ifdef PS2_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_spurious_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
